dm_sba_wide: RTL and testbench
==============================

// Module: dm_sba_wide
// PURPOSE
// Parametrised system-bus-access engine for the debug module. Executes debugger-issued sbcs/sbaddress/sbdata
// accesses on the master bus port, sits between dm_csrs and the SoC interconnect. Extends the current SBA with
// BusWidth 32/64/128, access sizes up to 128 bit, a bus timeout and a configurable max access size.
// PARAMETERS
// BusWidth       32  master bus / sbaddress / sbdata width; legal 32, 64, 128
// MaxAccessLog2  BusWidth==128?4:(BusWidth==64?3:2)  largest legal sbaccess (log2 bytes); must be <= $clog2(BusWidth/8)
// TimeoutCycles  1024  cycles waiting for gnt or r_valid before sberror=1; 0 disables timeout
// ReadByteEnable 1   1: drive size/offset byte enables on reads; 0: all-ones master_be_o on reads
// PORTS
// clk_i                    in  1            clock
// rst_ni                   in  1            asynchronous reset, active low
// dmactive_i               in  1            DM active; low = synchronous soft reset of engine
// master_req_o             out 1            bus request, held until master_gnt_i
// master_add_o             out BusWidth     bus address (byte)
// master_we_o              out 1            1 write, 0 read
// master_wdata_o           out BusWidth     write data, lane-shifted
// master_be_o              out BusWidth/8   byte enables
// master_gnt_i             in  1            request accepted
// master_r_valid_i         in  1            response valid (reads and writes)
// master_r_rdata_i         in  BusWidth     read data
// sbaddress_i              in  BusWidth     new sbaddress from CSRs
// sbaddress_o              out BusWidth     current sbaddress (incl. autoincrement)
// sbaddress_write_valid_i  in  1            debugger wrote sbaddress
// sbreadonaddr_i           in  1            sbcs.sbreadonaddr
// sbautoincrement_i        in  1            sbcs.sbautoincrement
// sbaccess_i               in  3            sbcs.sbaccess (log2 bytes)
// sbreadondata_i           in  1            sbcs.sbreadondata
// sbdata_i                 in  BusWidth     write data from CSRs
// sbdata_read_valid_i      in  1            debugger read sbdata
// sbdata_write_valid_i     in  1            debugger wrote sbdata
// sbdata_o                 out BusWidth     read data, right-aligned
// sbdata_valid_o           out 1            1-cycle pulse: sbdata_o valid
// sbbusy_o                 out 1            engine not Idle
// sberror_valid_o          out 1            1-cycle pulse: sberror_o valid
// sberror_o                out 3            1 timeout, 3 misaligned, 4 unsupported size
// BEHAVIOUR
// - Reset (rst_ni low): state=Idle, address reg=0, timeout cnt=0; all outputs 0.
// - FSM: Idle, Read, Write, WaitRead, WaitWrite. sbbusy_o = (state!=Idle).
// - Idle triggers, priority high->low: sbdata_write_valid_i -> Write; sbaddress_write_valid_i&sbreadonaddr_i -> Read;
//   sbdata_read_valid_i&sbreadondata_i -> Read. sbaddress_write_valid_i always loads address reg from sbaddress_i,
//   also when a write trigger wins the same cycle (write uses the newly loaded address).
// - Triggers while not Idle are ignored (dm_csrs flags sbbusyerror); address reg unchanged.
// - Checks at trigger, no bus access on failure, stay Idle, sberror_valid_o pulses next cycle:
//   sbaccess_i>MaxAccessLog2 -> 4; addr[sbaccess-1:0]!=0 -> 3. Size check wins over alignment.
// - Read/Write: master_req_o=1 from cycle after trigger until gnt; on gnt -> WaitRead/WaitWrite.
// - off = addr[$clog2(BusWidth/8)-1:0]; master_add_o = address reg;
//   be = ((1<<(1<<sbaccess))-1) << off; wdata = sbdata_i << 8*off; reads: be or all-ones per ReadByteEnable.
// - WaitRead: on r_valid, sbdata_o = rdata >> 8*off (upper bits zero beyond access size), sbdata_valid_o=1 same cycle, ->Idle.
// - WaitWrite: on r_valid -> Idle, no sbdata_valid_o.
// - Autoincrement: on completion, if sbautoincrement_i, addr += 1<<sbaccess, wraps mod 2^BusWidth.
// - Timeout: counter clears on each state entry, counts in Read/Write/WaitRead/WaitWrite; reaching TimeoutCycles
//   -> drop req, sberror_o=1 pulse, ->Idle, no autoincrement; a late r_valid in Idle is ignored.
// - gnt and r_valid same cycle: completes directly (Read->Idle with data pulse).
// - dmactive_i low: next cycle state=Idle, req dropped, address reg kept, in-flight response discarded.
// TESTING
// - BusWidth=64, sbaccess=2, addr 0x1004 write 0xDEADBEEF -> be=0xF0, wdata=0xDEADBEEF_00000000, 1 req cycle, busy until r_valid.
// - Read on addr write, sbaccess=0, addr 0x1003, rdata 0x..AB000000 -> sbdata_o=0xAB, valid pulse in r_valid cycle.
// - Autoincrement 4 reads sbaccess=2 from 0xFFFFFFF8 (BusWidth=32) -> addrs F8,FC,00,04; sbaddress_o=0x8 at end.
// - sbaccess=1, addr 0x1001 -> sberror_o=3, master_req_o never asserted; sbaccess=4 at BusWidth=64 -> sberror_o=4.
// - TimeoutCycles=8, gnt never given -> req drops, sberror_o=1 after 8 cycles, busy low, address unchanged.
// - dmactive_i low during WaitRead, then r_valid -> no sbdata_valid_o, state Idle; async rst_ni mid-Write -> all outputs 0.

Source files
------------

// File: rtl/dm_sba_wide.sv
// System-bus-access engine for the debug module: turns sbcs/sbaddress/sbdata
// activity into single, size-checked accesses on a 32/64/128-bit master port.
module dm_sba_wide #(
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned MaxAccessLog2  = (BusWidth == 128) ? 4 : ((BusWidth == 64) ? 3 : 2),
    parameter int unsigned TimeoutCycles  = 1024,
    parameter bit          ReadByteEnable = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o
);

    localparam int BeW  = int'(BusWidth / 8);
    localparam int OffW = $clog2(BeW);
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [2:0]      MaxSize = 3'(MaxAccessLog2);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ       = 3'd1,
        ST_WRITE      = 3'd2,
        ST_WAIT_READ  = 3'd3,
        ST_WAIT_WRITE = 3'd4
    } state_e;

    function automatic logic [BusWidth/8-1:0] lane_mask(input logic [2:0] size);
        logic [BusWidth/8-1:0] m;
        for (int i = 0; i < BeW; i++) begin
            m[i] = (i < (1 << size)) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    function automatic logic [BusWidth-1:0] data_mask(input logic [2:0] size);
        logic [BusWidth/8-1:0] lanes;
        logic [BusWidth-1:0]   m;
        lanes = lane_mask(size);
        for (int i = 0; i < BeW; i++) begin
            m[8*i +: 8] = {8{lanes[i]}};
        end
        return m;
    endfunction

    state_e              state_r;
    logic [BusWidth-1:0] addr_r;
    logic [BusWidth-1:0] wdata_r;
    logic [BeW-1:0]      be_r;
    logic                req_r;
    logic                we_r;
    logic [2:0]          size_r;
    logic [OffW-1:0]     off_r;
    logic [CntW-1:0]     cnt_r;
    logic                err_valid_r;
    logic [2:0]          err_r;

    logic [BusWidth-1:0] addr_next_s;
    logic [OffW-1:0]     off_next_s;
    logic                trig_write_s;
    logic                trig_read_s;
    logic                trig_s;
    logic                size_bad_s;
    logic                align_bad_s;
    logic [BeW-1:0]      be_next_s;
    logic [BusWidth-1:0] incr_s;
    logic                timeout_s;
    logic                data_valid_s;
    logic [BusWidth-1:0] rdata_s;

    // Trigger decode, access checks, lane steering and response alignment
    always_comb begin
        addr_next_s  = sbaddress_write_valid_i ? sbaddress_i : addr_r;
        off_next_s   = addr_next_s[OffW-1:0];
        trig_write_s = sbdata_write_valid_i;
        trig_read_s  = (sbaddress_write_valid_i && sbreadonaddr_i) ||
                       (sbdata_read_valid_i && sbreadondata_i);
        trig_s       = (state_r == ST_IDLE) && (trig_write_s || trig_read_s);
        size_bad_s   = (sbaccess_i > MaxSize);
        align_bad_s  = |(off_next_s & OffW'((32'd1 << sbaccess_i) - 32'd1));
        be_next_s    = lane_mask(sbaccess_i) << off_next_s;
        incr_s       = {{(BusWidth-8){1'b0}}, 8'd1} << size_r;
        timeout_s    = (TimeoutCycles != 0) && (cnt_r == CntLast);
        data_valid_s = dmactive_i && master_r_valid_i &&
                       ((state_r == ST_WAIT_READ) || ((state_r == ST_READ) && master_gnt_i));
        rdata_s      = data_valid_s ?
                       ((master_r_rdata_i >> {off_r, 3'b000}) & data_mask(size_r)) :
                       {BusWidth{1'b0}};
    end

    // Access FSM; a low dmactive_i returns to Idle but keeps the address register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            addr_r      <= {BusWidth{1'b0}};
            wdata_r     <= {BusWidth{1'b0}};
            be_r        <= {BeW{1'b0}};
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            size_r      <= 3'd0;
            off_r       <= {OffW{1'b0}};
            cnt_r       <= {CntW{1'b0}};
            err_valid_r <= 1'b0;
            err_r       <= 3'd0;
        end else if (!dmactive_i) begin
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            cnt_r       <= {CntW{1'b0}};
            err_valid_r <= 1'b0;
            err_r       <= 3'd0;
        end else begin
            err_valid_r <= 1'b0;
            err_r       <= 3'd0;
            case (state_r)
                ST_IDLE: begin
                    if (sbaddress_write_valid_i) begin
                        addr_r <= sbaddress_i;
                    end
                    if (trig_s) begin
                        // Size violation is reported in preference to misalignment
                        if (size_bad_s) begin
                            err_valid_r <= 1'b1;
                            err_r       <= 3'd4;
                        end else if (align_bad_s) begin
                            err_valid_r <= 1'b1;
                            err_r       <= 3'd3;
                        end else begin
                            state_r <= trig_write_s ? ST_WRITE : ST_READ;
                            req_r   <= 1'b1;
                            cnt_r   <= {CntW{1'b0}};
                            we_r    <= trig_write_s;
                            size_r  <= sbaccess_i;
                            off_r   <= off_next_s;
                            be_r    <= (trig_write_s || ReadByteEnable) ? be_next_s : {BeW{1'b1}};
                            wdata_r <= trig_write_s ? (sbdata_i << {off_next_s, 3'b000}) : {BusWidth{1'b0}};
                        end
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (master_gnt_i) begin
                        req_r <= 1'b0;
                        cnt_r <= {CntW{1'b0}};
                        if (master_r_valid_i) begin
                            state_r <= ST_IDLE;
                            if (sbautoincrement_i) begin
                                addr_r <= addr_r + incr_s;
                            end
                        end else begin
                            state_r <= (state_r == ST_READ) ? ST_WAIT_READ : ST_WAIT_WRITE;
                        end
                    end else if (timeout_s) begin
                        state_r     <= ST_IDLE;
                        req_r       <= 1'b0;
                        cnt_r       <= {CntW{1'b0}};
                        err_valid_r <= 1'b1;
                        err_r       <= 3'd1;
                    end else begin
                        cnt_r <= cnt_r + CntW'(1);
                    end
                end
                ST_WAIT_READ, ST_WAIT_WRITE: begin
                    if (master_r_valid_i) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CntW{1'b0}};
                        if (sbautoincrement_i) begin
                            addr_r <= addr_r + incr_s;
                        end
                    end else if (timeout_s) begin
                        state_r     <= ST_IDLE;
                        cnt_r       <= {CntW{1'b0}};
                        err_valid_r <= 1'b1;
                        err_r       <= 3'd1;
                    end else begin
                        cnt_r <= cnt_r + CntW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                    cnt_r   <= {CntW{1'b0}};
                end
            endcase
        end
    end

    assign master_req_o    = req_r;
    assign master_add_o    = addr_r;
    assign master_we_o     = we_r;
    assign master_wdata_o  = wdata_r;
    assign master_be_o     = be_r;
    assign sbaddress_o     = addr_r;
    assign sbdata_o        = rdata_s;
    assign sbdata_valid_o  = data_valid_s;
    assign sbbusy_o        = (state_r != ST_IDLE);
    assign sberror_valid_o = err_valid_r;
    assign sberror_o       = err_r;

endmodule

// File: tb/tb_dm_sba_wide.sv
// Scoreboard bench for dm_sba_wide at BusWidth=64, TimeoutCycles=8: expected bus
// requests, read data and error codes are queued at stimulus time and popped on DUT events.
module tb_dm_sba_wide;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        dmactive_i;
    logic        master_req_o;
    logic [63:0] master_add_o;
    logic        master_we_o;
    logic [63:0] master_wdata_o;
    logic [7:0]  master_be_o;
    logic        master_gnt_i;
    logic        master_r_valid_i;
    logic [63:0] master_r_rdata_i;
    logic [63:0] sbaddress_i;
    logic [63:0] sbaddress_o;
    logic        sbaddress_write_valid_i;
    logic        sbreadonaddr_i;
    logic        sbautoincrement_i;
    logic [2:0]  sbaccess_i;
    logic        sbreadondata_i;
    logic [63:0] sbdata_i;
    logic        sbdata_read_valid_i;
    logic        sbdata_write_valid_i;
    logic [63:0] sbdata_o;
    logic        sbdata_valid_o;
    logic        sbbusy_o;
    logic        sberror_valid_o;
    logic [2:0]  sberror_o;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  be;
        logic [63:0] wdata;
    } bus_t;

    bus_t        bus_q[$];
    logic [63:0] data_q[$];
    logic [2:0]  err_q[$];
    bus_t        mon_bus;
    logic [63:0] mon_data;
    logic [2:0]  mon_err;
    int          checks = 0;
    int          errors = 0;

    always #5 clk_i = ~clk_i;

    dm_sba_wide #(
        .BusWidth      (64),
        .TimeoutCycles (8),
        .ReadByteEnable(1'b1)
    ) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .dmactive_i             (dmactive_i),
        .master_req_o           (master_req_o),
        .master_add_o           (master_add_o),
        .master_we_o            (master_we_o),
        .master_wdata_o         (master_wdata_o),
        .master_be_o            (master_be_o),
        .master_gnt_i           (master_gnt_i),
        .master_r_valid_i       (master_r_valid_i),
        .master_r_rdata_i       (master_r_rdata_i),
        .sbaddress_i            (sbaddress_i),
        .sbaddress_o            (sbaddress_o),
        .sbaddress_write_valid_i(sbaddress_write_valid_i),
        .sbreadonaddr_i         (sbreadonaddr_i),
        .sbautoincrement_i      (sbautoincrement_i),
        .sbaccess_i             (sbaccess_i),
        .sbreadondata_i         (sbreadondata_i),
        .sbdata_i               (sbdata_i),
        .sbdata_read_valid_i    (sbdata_read_valid_i),
        .sbdata_write_valid_i   (sbdata_write_valid_i),
        .sbdata_o               (sbdata_o),
        .sbdata_valid_o         (sbdata_valid_o),
        .sbbusy_o               (sbbusy_o),
        .sberror_valid_o        (sberror_valid_o),
        .sberror_o              (sberror_o)
    );

    // Scoreboard monitor: compares every grant, data pulse and error pulse against the queues
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (master_req_o && master_gnt_i) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: addr=%h we=%b be=%h, required no access", master_add_o, master_we_o, master_be_o);
                end else begin
                    mon_bus = bus_q.pop_front();
                    if (master_add_o !== mon_bus.addr || master_we_o !== mon_bus.we || master_be_o !== mon_bus.be ||
                        (mon_bus.we && master_wdata_o !== mon_bus.wdata)) begin
                        errors++;
                        $display("FAIL bus_req: got addr=%h we=%b be=%h wdata=%h, required addr=%h we=%b be=%h wdata=%h",
                                 master_add_o, master_we_o, master_be_o, master_wdata_o,
                                 mon_bus.addr, mon_bus.we, mon_bus.be, mon_bus.wdata);
                    end
                end
            end
            if (sbdata_valid_o) begin
                checks++;
                if (data_q.size() == 0) begin
                    errors++;
                    $display("FAIL data_unexpected: sbdata_o=%h, required no pulse", sbdata_o);
                end else begin
                    mon_data = data_q.pop_front();
                    if (sbdata_o !== mon_data) begin
                        errors++;
                        $display("FAIL read_data: got %h, required %h", sbdata_o, mon_data);
                    end
                end
            end
            if (sberror_valid_o) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL error_unexpected: sberror_o=%0d, required no pulse", sberror_o);
                end else begin
                    mon_err = err_q.pop_front();
                    if (sberror_o !== mon_err) begin
                        errors++;
                        $display("FAIL error_code: got %0d, required %0d", sberror_o, mon_err);
                    end
                end
            end
        end
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_addr(input logic [63:0] a);
        sbaddress_i             = a;
        sbaddress_write_valid_i = 1'b1;
        cycle();
        sbaddress_write_valid_i = 1'b0;
    endtask

    task automatic write_data(input logic [63:0] d);
        sbdata_i             = d;
        sbdata_write_valid_i = 1'b1;
        cycle();
        sbdata_write_valid_i = 1'b0;
    endtask

    task automatic serve(input int gnt_delay, input int rsp_delay, input logic [63:0] rdata, input bit same_cycle);
        int n;
        n = 0;
        while (!master_req_o && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (!master_req_o) begin
            errors++;
            $display("FAIL serve_req: master_req_o=%b after %0d cycles, required 1", master_req_o, n);
        end else begin
            repeat (gnt_delay) cycle();
            master_gnt_i = 1'b1;
            if (same_cycle) begin
                master_r_valid_i = 1'b1;
                master_r_rdata_i = rdata;
            end
            cycle();
            master_gnt_i     = 1'b0;
            master_r_valid_i = 1'b0;
            if (!same_cycle) begin
                repeat (rsp_delay) cycle();
                master_r_valid_i = 1'b1;
                master_r_rdata_i = rdata;
                cycle();
                master_r_valid_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) cycle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({master_req_o, master_we_o, master_be_o, sbbusy_o, sbdata_valid_o, sberror_valid_o, sberror_o} !== 16'd0 ||
                master_add_o !== 64'd0 || master_wdata_o !== 64'd0 || sbaddress_o !== 64'd0 || sbdata_o !== 64'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: req=%b busy=%b be=%h add=%h sbaddr=%h, required all zero",
                         k, master_req_o, sbbusy_o, master_be_o, master_add_o, sbaddress_o);
            end
            rst_ni = 1'b1;
            cycle();
        end
    endtask

    task automatic test_write();
        sbreadonaddr_i = 1'b0;
        sbaccess_i     = 3'd2;
        write_addr(64'h1004);
        checks++;
        if (sbaddress_o !== 64'h1004 || sbbusy_o !== 1'b0) begin
            errors++;
            $display("FAIL write_addr_load: sbaddress_o=%h busy=%b, required 1004 busy=0", sbaddress_o, sbbusy_o);
        end
        bus_q.push_back('{64'h1004, 1'b1, 8'hF0, 64'hDEADBEEF_00000000});
        write_data(64'hDEADBEEF);
        checks++;
        if (master_req_o !== 1'b1 || sbbusy_o !== 1'b1) begin
            errors++;
            $display("FAIL write_req_start: req=%b busy=%b, required 1 1", master_req_o, sbbusy_o);
        end
        master_gnt_i = 1'b1;
        cycle();
        master_gnt_i = 1'b0;
        checks++;
        if (master_req_o !== 1'b0 || sbbusy_o !== 1'b1) begin
            errors++;
            $display("FAIL write_req_drop: req=%b busy=%b, required 0 1", master_req_o, sbbusy_o);
        end
        repeat (2) cycle();
        checks++;
        if (sbbusy_o !== 1'b1) begin
            errors++;
            $display("FAIL write_wait_busy: busy=%b, required 1", sbbusy_o);
        end
        master_r_valid_i = 1'b1;
        cycle();
        master_r_valid_i = 1'b0;
        checks++;
        if (sbbusy_o !== 1'b0 || sbaddress_o !== 64'h1004 || bus_q.size() != 0) begin
            errors++;
            $display("FAIL write_done: busy=%b sbaddr=%h pending=%0d, required 0 1004 0", sbbusy_o, sbaddress_o, bus_q.size());
        end
    endtask

    task automatic test_read_on_addr();
        sbreadonaddr_i = 1'b1;
        sbaccess_i     = 3'd0;
        bus_q.push_back('{64'h1003, 1'b0, 8'h08, 64'd0});
        data_q.push_back(64'hAB);
        write_addr(64'h1003);
        serve(2, 1, 64'h11223344_AB000000, 1'b0);
        cycle();
        checks++;
        if (sbbusy_o !== 1'b0 || data_q.size() != 0 || bus_q.size() != 0) begin
            errors++;
            $display("FAIL read_on_addr_done: busy=%b pending data=%0d bus=%0d, required 0 0 0", sbbusy_o, data_q.size(), bus_q.size());
        end
        sbreadonaddr_i = 1'b0;
    endtask

    task automatic test_autoincrement();
        logic [63:0] base;
        logic [63:0] a;
        logic [63:0] rd;
        logic [2:0]  off;
        base              = 64'hFFFFFFFF_FFFFFFF8;
        sbreadonaddr_i    = 1'b1;
        sbreadondata_i    = 1'b1;
        sbautoincrement_i = 1'b1;
        sbaccess_i        = 3'd2;
        for (int i = 0; i < 4; i++) begin
            a   = base + 64'(4 * i);
            off = a[2:0];
            rd  = {32'h13570000 + 32'(i), 32'h24680000 + 32'(i)};
            bus_q.push_back('{a, 1'b0, (off == 3'd4) ? 8'hF0 : 8'h0F, 64'd0});
            data_q.push_back((off == 3'd4) ? {32'd0, rd[63:32]} : {32'd0, rd[31:0]});
            if (i == 0) begin
                write_addr(base);
            end else begin
                sbdata_read_valid_i = 1'b1;
                cycle();
                sbdata_read_valid_i = 1'b0;
            end
            serve(i, 1, rd, i == 2);
        end
        cycle();
        checks++;
        if (sbaddress_o !== 64'h8 || sbbusy_o !== 1'b0 || bus_q.size() != 0 || data_q.size() != 0) begin
            errors++;
            $display("FAIL autoinc_end: sbaddr=%h busy=%b pending bus=%0d data=%0d, required 8 0 0 0",
                     sbaddress_o, sbbusy_o, bus_q.size(), data_q.size());
        end
        sbreadonaddr_i    = 1'b0;
        sbreadondata_i    = 1'b0;
        sbautoincrement_i = 1'b0;
    endtask

    task automatic test_busy_ignore();
        sbreadonaddr_i = 1'b1;
        sbaccess_i     = 3'd3;
        bus_q.push_back('{64'h4000, 1'b0, 8'hFF, 64'd0});
        data_q.push_back(64'h01234567_89ABCDEF);
        write_addr(64'h4000);
        sbaddress_i             = 64'h5000;
        sbaddress_write_valid_i = 1'b1;
        sbdata_write_valid_i    = 1'b1;
        cycle();
        sbaddress_write_valid_i = 1'b0;
        sbdata_write_valid_i    = 1'b0;
        checks++;
        if (sbaddress_o !== 64'h4000 || sbbusy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore_addr: sbaddr=%h busy=%b, required 4000 1", sbaddress_o, sbbusy_o);
        end
        serve(0, 2, 64'h01234567_89ABCDEF, 1'b0);
        repeat (3) cycle();
        checks++;
        if (sbaddress_o !== 64'h4000 || sbbusy_o !== 1'b0 || bus_q.size() != 0 || data_q.size() != 0) begin
            errors++;
            $display("FAIL busy_ignore_end: sbaddr=%h busy=%b pending bus=%0d data=%0d, required 4000 0 0 0",
                     sbaddress_o, sbbusy_o, bus_q.size(), data_q.size());
        end
        sbreadonaddr_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        sbreadonaddr_i = 1'b1;
        sbreadondata_i = 1'b1;
        sbaccess_i     = 3'd3;
        bus_q.push_back('{64'h7008, 1'b1, 8'hFF, 64'h11112222_33334444});
        sbaddress_i             = 64'h7008;
        sbaddress_write_valid_i = 1'b1;
        sbdata_i                = 64'h11112222_33334444;
        sbdata_write_valid_i    = 1'b1;
        cycle();
        sbaddress_write_valid_i = 1'b0;
        sbdata_write_valid_i    = 1'b0;
        checks++;
        if (master_we_o !== 1'b1 || master_req_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write_wins: we=%b req=%b, required 1 1", master_we_o, master_req_o);
        end
        serve(0, 0, 64'd0, 1'b1);
        bus_q.push_back('{64'h7008, 1'b0, 8'hFF, 64'd0});
        data_q.push_back(64'h55556666_77778888);
        sbdata_read_valid_i = 1'b1;
        cycle();
        sbdata_read_valid_i = 1'b0;
        serve(1, 0, 64'h55556666_77778888, 1'b0);
        cycle();
        checks++;
        if (sbbusy_o !== 1'b0 || bus_q.size() != 0 || data_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_end: busy=%b pending bus=%0d data=%0d, required 0 0 0", sbbusy_o, bus_q.size(), data_q.size());
        end
        sbreadonaddr_i = 1'b0;
        sbreadondata_i = 1'b0;
    endtask

    task automatic test_errors();
        logic [63:0] t_addr[5] = '{64'h1001, 64'h1000, 64'h1001, 64'h1004, 64'h1002};
        logic [2:0]  t_size[5] = '{3'd1, 3'd4, 3'd4, 3'd3, 3'd2};
        logic        t_wr[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  t_err[5]  = '{3'd3, 3'd4, 3'd4, 3'd3, 3'd3};
        logic        seen;
        for (int i = 0; i < 5; i++) begin
            sbaccess_i     = t_size[i];
            sbreadonaddr_i = !t_wr[i];
            err_q.push_back(t_err[i]);
            write_addr(t_addr[i]);
            if (t_wr[i]) begin
                write_data(64'hA5A5A5A5_A5A5A5A5);
            end
            seen = 1'b0;
            repeat (3) begin
                seen = seen | master_req_o | sbbusy_o;
                cycle();
            end
            checks++;
            if (seen !== 1'b0 || err_q.size() != 0) begin
                errors++;
                $display("FAIL access_error[%0d]: req_or_busy_seen=%b pending err=%0d, required 0 0", i, seen, err_q.size());
            end
        end
        sbreadonaddr_i = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        sbreadonaddr_i = 1'b1;
        sbaccess_i     = 3'd3;
        err_q.push_back(3'd1);
        write_addr(64'h2000);
        n = 0;
        while (master_req_o && n < 20) begin
            n++;
            cycle();
        end
        checks++;
        if (n != 8 || sbbusy_o !== 1'b0 || sbaddress_o !== 64'h2000) begin
            errors++;
            $display("FAIL timeout: req cycles=%0d busy=%b sbaddr=%h, required 8 0 2000", n, sbbusy_o, sbaddress_o);
        end
        cycle();
        master_r_valid_i = 1'b1;
        master_r_rdata_i = 64'hBAD0BAD0_BAD0BAD0;
        cycle();
        master_r_valid_i = 1'b0;
        cycle();
        checks++;
        if (sbbusy_o !== 1'b0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_late_rsp: busy=%b pending err=%0d, required 0 0", sbbusy_o, err_q.size());
        end
        sbreadonaddr_i = 1'b0;
    endtask

    task automatic test_dmactive();
        sbreadonaddr_i = 1'b1;
        sbaccess_i     = 3'd3;
        bus_q.push_back('{64'h3000, 1'b0, 8'hFF, 64'd0});
        write_addr(64'h3000);
        master_gnt_i = 1'b1;
        cycle();
        master_gnt_i = 1'b0;
        checks++;
        if (sbbusy_o !== 1'b1 || master_req_o !== 1'b0) begin
            errors++;
            $display("FAIL dmactive_waitread: busy=%b req=%b, required 1 0", sbbusy_o, master_req_o);
        end
        dmactive_i = 1'b0;
        cycle();
        dmactive_i = 1'b1;
        checks++;
        if (sbbusy_o !== 1'b0 || master_req_o !== 1'b0 || sbaddress_o !== 64'h3000) begin
            errors++;
            $display("FAIL dmactive_idle: busy=%b req=%b sbaddr=%h, required 0 0 3000", sbbusy_o, master_req_o, sbaddress_o);
        end
        master_r_valid_i = 1'b1;
        master_r_rdata_i = 64'h0F0F0F0F_0F0F0F0F;
        cycle();
        master_r_valid_i = 1'b0;
        cycle();
        checks++;
        if (sbbusy_o !== 1'b0 || bus_q.size() != 0) begin
            errors++;
            $display("FAIL dmactive_discard: busy=%b pending bus=%0d, required 0 0", sbbusy_o, bus_q.size());
        end
        sbreadonaddr_i = 1'b0;
    endtask

    task automatic test_async_reset();
        sbreadonaddr_i = 1'b0;
        sbaccess_i     = 3'd3;
        write_addr(64'h6000);
        write_data(64'hFACEFACE_FACEFACE);
        cycle();
        checks++;
        if (master_req_o !== 1'b1 || master_we_o !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: req=%b we=%b, required 1 1", master_req_o, master_we_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({master_req_o, master_we_o, master_be_o, sbbusy_o, sbdata_valid_o, sberror_valid_o, sberror_o} !== 16'd0 ||
            master_add_o !== 64'd0 || master_wdata_o !== 64'd0 || sbaddress_o !== 64'd0 || sbdata_o !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: req=%b we=%b be=%h busy=%b add=%h wdata=%h, required all zero",
                     master_req_o, master_we_o, master_be_o, sbbusy_o, master_add_o, master_wdata_o);
        end
        cycle();
        rst_ni = 1'b1;
        repeat (2) cycle();
        checks++;
        if (sbbusy_o !== 1'b0 || master_req_o !== 1'b0) begin
            errors++;
            $display("FAIL async_release: busy=%b req=%b, required 0 0", sbbusy_o, master_req_o);
        end
    endtask

    initial begin
        rst_ni                  = 1'b0;
        dmactive_i              = 1'b1;
        master_gnt_i            = 1'b0;
        master_r_valid_i        = 1'b0;
        master_r_rdata_i        = 64'd0;
        sbaddress_i             = 64'd0;
        sbaddress_write_valid_i = 1'b0;
        sbreadonaddr_i          = 1'b0;
        sbautoincrement_i       = 1'b0;
        sbaccess_i              = 3'd0;
        sbreadondata_i          = 1'b0;
        sbdata_i                = 64'd0;
        sbdata_read_valid_i     = 1'b0;
        sbdata_write_valid_i    = 1'b0;

        test_reset();
        test_write();
        test_read_on_addr();
        test_autoincrement();
        test_busy_ignore();
        test_back_to_back();
        test_errors();
        test_timeout();
        test_dmactive();
        test_async_reset();

        checks++;
        if (bus_q.size() != 0 || data_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL final_queues: pending bus=%0d data=%0d err=%0d, required 0 0 0",
                     bus_q.size(), data_q.size(), err_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
